// File: rtl/uar_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uar_rx_ctrl
// Description : Receive-side controller between the uar receiver outputs and
//               a host read port.
//
//               - Each rising edge of dReady is one completed frame.
//               - {dError, dOut} is stored in a DEPTH-entry first-word
//                 fall-through FIFO.
//               - The FIFO head is served over a valid/ready handshake.
//               - Overrun and frame-error statistics are kept as
//                 software-clearable status.
//
// Optional    : define UAR_RX_IRQ_EN to build the registered irq output.
//               When it is undefined, irq is tied low and THRESH is unused.
//
// Ports       : clk        - system clock, rising edge
//               gl_reset   - asynchronous active-low reset
//               dOut       - received byte
//               dReady     - receiver frame-complete level
//               dError     - receiver stop-bit error, valid with dReady
//               rd_valid   - FIFO head valid
//               rd_data    - FIFO head data
//               rd_err     - FIFO head error tag
//               rd_ready   - host accepts the head
//               level      - FIFO occupancy, 0..DEPTH
//               overrun    - sticky: a frame was dropped because the FIFO
//                            was full
//               err_cnt    - saturating count of frames with dError=1
//               clr_status - pulse; clears overrun and err_cnt
//               flush      - pulse; empties the FIFO
//               irq        - interrupt (optional)
//
// Revision    : 1.0 - initial release
// ============================================================================
module uar_rx_ctrl #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int THRESH = 4
) (
    input  logic          clk,
    input  logic          gl_reset,
    input  logic [7:0]    dOut,
    input  logic          dReady,
    input  logic          dError,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic          rd_err,
    input  logic          rd_ready,
    output logic [AW:0]   level,
    output logic          overrun,
    output logic [7:0]    err_cnt,
    input  logic          clr_status,
    input  logic          flush,
    output logic          irq
);

    localparam logic [AW:0] c_FULL_LVL = (AW+1)'(DEPTH);

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH < 2 || (1 << AW) != DEPTH || THRESH < 1 || THRESH > DEPTH) begin : g_param_check
        $error("uar_rx_ctrl: invalid DEPTH/AW/THRESH combination");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic          dready_q;
    logic [AW-1:0] wptr_q,    wptr_d;
    logic [AW-1:0] rptr_q,    rptr_d;
    logic [AW:0]   level_q,   level_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [8:0]    mem_q [DEPTH];

    logic          w_ev;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic [8:0]    w_head;

    // ------------------------------------------------------------------------
    // Frame detection and FIFO control
    // ------------------------------------------------------------------------
    assign w_ev   = dReady & ~dready_q;
    assign w_full = (level_q == c_FULL_LVL);

    // A pop in the same cycle frees a slot for a push that arrives while full.
    // A flush overrides both push and pop; its frame is discarded silently.
    assign w_pop  = rd_valid & rd_ready & ~flush;
    assign w_push = w_ev & (~w_full | w_pop) & ~flush;
    assign w_drop = w_ev & w_full & ~w_pop & ~flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            rptr_d  = wptr_q;
            level_d = '0;
        end else begin
            if (w_push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (w_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status: a coincident event wins over clr_status.
    // ------------------------------------------------------------------------
    always_comb begin
        overrun_d = overrun_q;
        if (clr_status) begin
            overrun_d = 1'b0;
        end
        if (w_drop) begin
            overrun_d = 1'b1;
        end
    end

    // Error frames count even when dropped or flushed.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_status) begin
            err_cnt_d = '0;
        end
        if (w_ev && dError) begin
            if (clr_status) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // dready_q resets high so a level already present at reset release is not
    // mistaken for a new frame.
    always_ff @(posedge clk or negedge gl_reset) begin
        if (!gl_reset) begin
            dready_q  <= 1'b1;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            dready_q  <= dReady;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset; only entries below level are ever presented.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= {dError, dOut};
        end
    end

    // ------------------------------------------------------------------------
    // Read port (first-word fall-through)
    // ------------------------------------------------------------------------
    assign w_head   = mem_q[rptr_q];
    assign rd_valid = (level_q != '0);
    assign rd_data  = w_head[7:0];
    assign rd_err   = w_head[8];
    assign level    = level_q;
    assign overrun  = overrun_q;
    assign err_cnt  = err_cnt_q;

    // ------------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------------
`ifdef UAR_RX_IRQ_EN
    localparam logic [AW:0] c_THRESH = (AW+1)'(THRESH);

    logic irq_q, irq_d;

    assign irq_d = (level_d >= c_THRESH) | overrun_d | (err_cnt_d != 8'd0);

    always_ff @(posedge clk or negedge gl_reset) begin
        if (!gl_reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uar_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uar_rx_ctrl
// Description : Self-checking bench for uar_rx_ctrl. A queue-based reference
//               model predicts FIFO contents and status; directed scenarios
//               are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uar_rx_ctrl;

    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int THRESH = 4;

    logic          clk = 1'b0;
    logic          gl_reset;
    logic [7:0]    dOut;
    logic          dReady;
    logic          dError;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_err;
    logic          rd_ready;
    logic [AW:0]   level;
    logic          overrun;
    logic [7:0]    err_cnt;
    logic          clr_status;
    logic          flush;
    logic          irq;

    uar_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH)) dut (
        .clk        (clk),
        .gl_reset   (gl_reset),
        .dOut       (dOut),
        .dReady     (dReady),
        .dError     (dError),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .rd_ready   (rd_ready),
        .level      (level),
        .overrun    (overrun),
        .err_cnt    (err_cnt),
        .clr_status (clr_status),
        .flush      (flush),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [8:0] m_q[$];
    bit         m_prev;
    bit         m_ov;
    int         m_ec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_irq();
`ifdef UAR_RX_IRQ_EN
        return (m_q.size() >= THRESH) || m_ov || (m_ec != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all(input string ctx);
        chk({ctx, ":level"},    32'(level),    32'(m_q.size()));
        chk({ctx, ":rd_valid"}, 32'(rd_valid), 32'(m_q.size() != 0));
        chk({ctx, ":overrun"},  32'(overrun),  32'(m_ov));
        chk({ctx, ":err_cnt"},  32'(err_cnt),  32'(m_ec));
        chk({ctx, ":irq"},      32'(irq),      32'(exp_irq()));
        if (m_q.size() != 0) begin
            chk({ctx, ":rd_data"}, 32'(rd_data), 32'(m_q[0][7:0]));
            chk({ctx, ":rd_err"},  32'(rd_err),  32'(m_q[0][8]));
        end
    endtask

    // One clock with the currently driven inputs: update the model from the
    // same inputs the DUT sees at the edge, then compare after the edge.
    task automatic step(input string ctx);
        bit ev, pop;
        ev  = dReady && !m_prev;
        pop = rd_ready && (m_q.size() != 0);
        m_prev = dReady;
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (m_q.size() < DEPTH) m_q.push_back({dError, dOut});
            end
        end
        if (clr_status) begin
            m_ov = 0;
            m_ec = 0;
        end
        if (ev && !flush && !pop && m_q.size() == DEPTH && !(m_q.size() < DEPTH)) begin
            // frame could not be stored: the queue was full before and nothing left
        end
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    // Send one frame: a low cycle then the rising edge carrying the data.
    task automatic frame(input logic [7:0] d, input logic e, input string ctx);
        dReady = 1'b0;
        step(ctx);
        dReady = 1'b1;
        dOut   = d;
        dError = e;
        note_event();
        step(ctx);
    endtask

    // Overrun / error-count bookkeeping for the event about to be clocked.
    // Kept separate so the random phase can reuse it.
    task automatic note_event();
        bit ev, pop;
        ev  = dReady && !m_prev;
        pop = rd_ready && (m_q.size() != 0);
        if (ev) begin
            if (!flush && !pop && m_q.size() == DEPTH) m_ov = 1;
            if (dError) m_ec = (m_ec == 255) ? 255 : m_ec + 1;
        end
    endtask

    // Apply clr_status ahead of the event so "event wins" ordering holds:
    // step() clears first, so the event effect must be re-applied after.
    task automatic step_ev(input string ctx);
        bit ev, pop, ov_hit, err_hit;
        ev      = dReady && !m_prev;
        pop     = rd_ready && (m_q.size() != 0);
        ov_hit  = ev && !flush && !pop && (m_q.size() == DEPTH);
        err_hit = ev && dError;
        if (clr_status) begin
            m_ov = 0;
            m_ec = 0;
        end
        if (ov_hit)  m_ov = 1;
        if (err_hit) m_ec = (m_ec == 255) ? 255 : m_ec + 1;
        // step() must not clear again
        begin
            logic saved_clr;
            saved_clr  = clr_status;
            clr_status = 1'b0;
            step_model_only(ev, pop);
            clr_status = saved_clr;
        end
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic step_model_only(input bit ev, input bit pop);
        m_prev = dReady;
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (ev && m_q.size() < DEPTH) m_q.push_back({dError, dOut});
        end
    endtask

    task automatic send(input logic [7:0] d, input logic e, input string ctx);
        dReady = 1'b0;
        step_ev(ctx);
        dReady = 1'b1;
        dOut   = d;
        dError = e;
        step_ev(ctx);
    endtask

    initial begin
        int start_ec;
        gl_reset   = 1'b0;
        dReady     = 1'b1;
        dOut       = 8'h00;
        dError     = 1'b0;
        rd_ready   = 1'b0;
        clr_status = 1'b0;
        flush      = 1'b0;
        m_q.delete();
        m_prev = 1;
        m_ov   = 0;
        m_ec   = 0;

        // ---------------- reset with dReady held high ----------------
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_active");
        gl_reset = 1'b1;
        repeat (3) step_ev("reset_release_dready_high");

        // ---------------- single frame ----------------
        dReady = 1'b0;
        step_ev("single_low");
        dReady = 1'b1;
        dOut   = 8'hA5;
        dError = 1'b0;
        step_ev("single_ev");
        chk("single_data_A5", 32'(rd_data), 32'h0000_00A5);
        chk("single_level1",  32'(level),   32'd1);
        rd_ready = 1'b1;
        step_ev("single_pop");
        chk("single_empty", 32'(rd_valid), 32'd0);
        rd_ready = 1'b0;

        // ---------------- fill and overrun ----------------
        for (int i = 0; i < 8; i++) send(8'(i), 1'b0, "fill");
        chk("fill_level8", 32'(level), 32'd8);
        send(8'h08, 1'b0, "ninth");
        chk("ninth_overrun", 32'(overrun), 32'd1);
        chk("ninth_head",    32'(rd_data), 32'd0);
        dReady   = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            step_ev("drain");
        end
        rd_ready = 1'b0;

        // ---------------- full with simultaneous pop ----------------
        clr_status = 1'b1;
        step_ev("clr_before_full");
        clr_status = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 1'b0, "refill");
        dReady = 1'b0;
        step_ev("full_low");
        dReady   = 1'b1;
        dOut     = 8'h55;
        rd_ready = 1'b1;
        step_ev("full_push_pop");
        chk("full_pp_overrun", 32'(overrun), 32'd0);
        chk("full_pp_level",   32'(level),   32'd8);
        dReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("full_pp_last55", 32'(rd_data), 32'h55);
            step_ev("full_pp_drain");
        end

        // ---------------- error counting with continuous drain ----------------
        rd_ready = 1'b1;
        for (int i = 0; i < 300; i++) send(8'($urandom), 1'b1, "err_frames");
        chk("err_saturated", 32'(err_cnt), 32'd255);
        dReady = 1'b0;
        step_ev("err_low");
        dReady     = 1'b1;
        dError     = 1'b1;
        clr_status = 1'b1;
        step_ev("clr_with_err");
        clr_status = 1'b0;
        chk("clr_event_wins", 32'(err_cnt), 32'd1);
        dReady = 1'b0;
        repeat (3) step_ev("err_settle");
        rd_ready = 1'b0;

        // ---------------- flush with coincident error event ----------------
        for (int i = 0; i < 3; i++) send(8'(8'hC0 + i), 1'b0, "pre_flush");
        chk("pre_flush_level3", 32'(level), 32'd3);
        start_ec = m_ec;
        dReady = 1'b0;
        step_ev("flush_low");
        dReady = 1'b1;
        dError = 1'b1;
        dOut   = 8'hEE;
        flush  = 1'b1;
        step_ev("flush_ev");
        flush = 1'b0;
        chk("flush_level0",  32'(level),    32'd0);
        chk("flush_invalid", 32'(rd_valid), 32'd0);
        chk("flush_errcnt",  32'(err_cnt),  32'(start_ec + 1));
        dReady = 1'b0;
        step_ev("flush_after");

        // ---------------- randomized phase ----------------
        for (int i = 0; i < 1500; i++) begin
            dReady     = 1'($urandom_range(0, 1));
            dOut       = 8'($urandom);
            dError     = 1'($urandom_range(0, 1));
            rd_ready   = ($urandom_range(0, 2) == 0);
            clr_status = ($urandom_range(0, 23) == 0);
            flush      = ($urandom_range(0, 47) == 0);
            step_ev("random");
        end
        clr_status = 1'b0;
        flush      = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
